// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int MD_XLEN = 32;
    localparam int CNT_W   = $clog2(MD_XLEN);

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } md_state_e;

    function automatic logic op_a_signed(input md_op_e op);
        return (op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
    endfunction

    function automatic logic op_b_signed(input md_op_e op);
        return (op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM});
    endfunction

endpackage

// File: rtl/muldiv_iter_unit_if.sv
// Issue/result bus between the EX stage and the multiply/divide unit.
interface muldiv_iter_unit_if
    import muldiv_pkg::*;
#(
    parameter int XLEN = MD_XLEN
);
    logic            start;
    logic [2:0]      func3;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, func3, rs1_data, rs2_data, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, func3, rs1_data, rs2_data, flush,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_sign_fix.sv
// Two-lane conditional two's-complement negation; used for operand abs-value and result sign restore.
module muldiv_sign_fix #(
    parameter int WA = 32,
    parameter int WB = 32
) (
    input  logic [WA-1:0] i_a,
    input  logic          i_neg_a,
    input  logic [WB-1:0] i_b,
    input  logic          i_neg_b,
    output logic [WA-1:0] o_a,
    output logic [WB-1:0] o_b
);
    assign o_a = i_neg_a ? -i_a : i_a;
    assign o_b = i_neg_b ? -i_b : i_b;
endmodule

// File: rtl/muldiv_iter_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply, restoring divide, one bit per clock.
//   state | meaning
//   IDLE  | no op in flight, waiting for start
//   CALC  | iterating, one bit per cycle, busy=1
//   DONE  | result valid, done=1 for this cycle, new start accepted
module muldiv_iter_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = MD_XLEN
) (
    input  logic              clk,
    input  logic              reset,
    muldiv_iter_unit_if.slave bus
);
    localparam int CW = $clog2(XLEN);

    md_state_e         r_state, w_state_nxt;
    md_op_e            r_op, w_op_in;
    logic [CW-1:0]     r_cnt;
    logic [2*XLEN-1:0] r_acc, w_acc_nxt;
    logic [XLEN-1:0]   r_opnd, r_result;
    logic              r_neg_a, r_neg_b;

    logic              w_accept, w_busy, w_done, w_last, w_is_div;
    logic              w_a_neg_in, w_b_neg_in, w_div_zero, w_ovf, w_fast;
    logic [XLEN-1:0]   w_abs_a, w_abs_b, w_fast_res, w_final_res;
    logic [XLEN:0]     w_mul_sum, w_div_trial, w_div_diff;
    logic [XLEN-1:0]   w_rem_nxt;
    logic              w_q_bit;
    logic [2*XLEN-1:0] w_res_a;
    logic [XLEN-1:0]   w_res_b;

    assign w_op_in    = md_op_e'(bus.func3);
    assign w_a_neg_in = op_a_signed(w_op_in) & bus.rs1_data[XLEN-1];
    assign w_b_neg_in = op_b_signed(w_op_in) & bus.rs2_data[XLEN-1];

    muldiv_sign_fix #(.WA(XLEN), .WB(XLEN)) u_opnd_fix (
        .i_a(bus.rs1_data), .i_neg_a(w_a_neg_in),
        .i_b(bus.rs2_data), .i_neg_b(w_b_neg_in),
        .o_a(w_abs_a),      .o_b(w_abs_b)
    );

    // Divide-by-zero and signed overflow bypass the iteration entirely.
    assign w_div_zero = (bus.rs2_data == '0);
    assign w_ovf      = (w_op_in inside {OP_DIV, OP_REM})
                      && (bus.rs1_data == {1'b1, {(XLEN-1){1'b0}}})
                      && (bus.rs2_data == '1);
    assign w_fast     = bus.func3[2] & (w_div_zero | w_ovf);
    assign w_fast_res = w_div_zero ? (bus.func3[1] ? bus.rs1_data : '1)
                                   : (bus.func3[1] ? '0 : bus.rs1_data);

    assign w_is_div = (r_op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU});
    assign w_last   = (r_cnt == CW'(XLEN-1));

    always_comb begin
        w_mul_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
        w_div_trial = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
        w_div_diff  = w_div_trial - {1'b0, r_opnd};
        w_q_bit     = ~w_div_diff[XLEN];
        w_rem_nxt   = w_q_bit ? w_div_diff[XLEN-1:0] : w_div_trial[XLEN-1:0];
        w_acc_nxt   = w_is_div ? {w_rem_nxt, r_acc[XLEN-2:0], w_q_bit}
                               : {w_mul_sum, r_acc[XLEN-1:1]};
    end

    // Remainder follows the dividend's sign; product/quotient follow the XOR of both.
    muldiv_sign_fix #(.WA(2*XLEN), .WB(XLEN)) u_res_fix (
        .i_a(w_is_div ? {{XLEN{1'b0}}, w_acc_nxt[XLEN-1:0]} : w_acc_nxt),
        .i_neg_a(r_neg_a ^ r_neg_b),
        .i_b(w_acc_nxt[2*XLEN-1:XLEN]),
        .i_neg_b(r_neg_a),
        .o_a(w_res_a),
        .o_b(w_res_b)
    );

    always_comb begin
        w_final_res = w_res_a[XLEN-1:0];
        case (r_op)
            OP_MULH, OP_MULHSU, OP_MULHU: w_final_res = w_res_a[2*XLEN-1:XLEN];
            OP_REM, OP_REMU:              w_final_res = w_res_b;
            default:                      w_final_res = w_res_a[XLEN-1:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = (r_state == CALC);
        w_done      = (r_state == DONE);
        w_accept    = bus.start & ~w_busy & ~bus.flush;
        case (r_state)
            IDLE, DONE: begin
                if (w_accept) w_state_nxt = w_fast ? DONE : CALC;
                else          w_state_nxt = IDLE;
            end
            CALC: begin
                if (bus.flush)   w_state_nxt = IDLE;
                else if (w_last) w_state_nxt = DONE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op     <= OP_MUL;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_result <= '0;
        end else if (w_accept) begin
            r_op    <= w_op_in;
            r_cnt   <= '0;
            r_neg_a <= w_a_neg_in;
            r_neg_b <= w_b_neg_in;
            // Divide shifts the dividend out of the low half; multiply shifts the multiplier.
            if (bus.func3[2]) begin
                r_acc  <= {{XLEN{1'b0}}, w_abs_a};
                r_opnd <= w_abs_b;
            end else begin
                r_acc  <= {{XLEN{1'b0}}, w_abs_b};
                r_opnd <= w_abs_a;
            end
            if (w_fast) r_result <= w_fast_res;
        end else if (r_state == CALC) begin
            if (bus.flush) begin
                r_cnt <= '0;
            end else begin
                r_acc <= w_acc_nxt;
                r_cnt <= r_cnt + CW'(1);
                if (w_last) r_result <= w_final_res;
            end
        end
    end

    assign bus.busy   = w_busy;
    assign bus.done   = w_done;
    assign bus.result = r_result;

endmodule
